// File: rtl/div_sequencer.sv
// Sequencer wrapping a fixed 32-bit unsigned iterative divider for RV32M DIV/DIVU/REM/REMU.
// Handles operand sign conversion, the ISA special cases, result sign fix and pipeline flush.
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush_in,
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] rs1_in,
  input  logic [WIDTH-1:0] rs2_in,
  output logic             resp_valid_out,
  input  logic             resp_ready_in,
  output logic [WIDTH-1:0] result_out,
  output logic             busy_out,
  output logic             div_valid_out,
  output logic [WIDTH-1:0] div_dividend_out,
  output logic [WIDTH-1:0] div_divisor_out,
  input  logic [WIDTH-1:0] div_quotient_in,
  input  logic [WIDTH-1:0] div_remainder_in,
  input  logic             div_valid_in
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

  state_t           state, state_nxt;
  logic             is_rem_q, neg_q;
  logic             is_signed, is_rem, rs1_neg, rs2_neg;
  logic             accept, div0, ovf, special;
  logic [WIDTH-1:0] abs1, abs2, special_result, raw, fixed;

  always_comb begin
    is_signed = ~op_in[0];
    is_rem    = op_in[1];
    rs1_neg   = is_signed & rs1_in[WIDTH-1];
    rs2_neg   = is_signed & rs2_in[WIDTH-1];
    abs1      = rs1_neg ? ('0 - rs1_in) : rs1_in;
    abs2      = rs2_neg ? ('0 - rs2_in) : rs2_in;
    div0      = (rs2_in == '0);
    ovf       = is_signed & (rs1_in == {1'b1, {(WIDTH-1){1'b0}}}) & (rs2_in == '1);
    special   = div0 | ovf;
    // Overflow quotient equals the dividend itself (most negative value)
    if (div0) special_result = is_rem ? rs1_in : '1;
    else      special_result = is_rem ? '0 : rs1_in;
    raw       = is_rem_q ? div_remainder_in : div_quotient_in;
    fixed     = neg_q ? ('0 - raw) : raw;
  end

  assign req_ready_out  = rst_n_in & (state == S_IDLE) & ~flush_in;
  assign accept         = req_valid_in & req_ready_out;
  assign resp_valid_out = (state == S_RESP);
  assign busy_out       = (state != S_IDLE);
  assign div_valid_out  = (state == S_ISSUE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = special ? S_RESP : S_ISSUE;
      S_ISSUE: state_nxt = flush_in ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (div_valid_in)  state_nxt = flush_in ? S_IDLE : S_RESP;
        else if (flush_in) state_nxt = S_DRAIN;
      end
      S_RESP:  if (flush_in || resp_ready_in) state_nxt = S_IDLE;
      S_DRAIN: if (div_valid_in) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= S_IDLE;
      is_rem_q         <= 1'b0;
      neg_q            <= 1'b0;
      result_out       <= '0;
      div_dividend_out <= '0;
      div_divisor_out  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        is_rem_q <= is_rem;
        // Remainder takes the dividend's sign; quotient the XOR of both signs
        neg_q    <= is_rem ? rs1_neg : (rs1_neg ^ rs2_neg);
        if (special) begin
          result_out <= special_result;
        end else begin
          div_dividend_out <= abs1;
          div_divisor_out  <= abs2;
        end
      end
      if (state == S_WAIT && div_valid_in && !flush_in) result_out <= fixed;
    end
  end

endmodule
